// File: rtl/cache_controller.sv
// Direct-mapped read-only cache controller: 1024 lines x 4 words, 3-bit tag, line fill from word memory.
// Define CACHE_HIT_COUNTER_EN to add the saturating hitCount/missCount statistics outputs.
module cache_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpuRead,
  input  logic [14:0] cpuAddr,
  output logic        cpuReady,
  output logic [31:0] cpuData,
  output logic [9:0]  indx,
  output logic [2:0]  TagIn,
  input  logic        valid,
  input  logic [2:0]  TagOut,
  input  logic [31:0] writeData0,
  input  logic [31:0] writeData1,
  input  logic [31:0] writeData2,
  input  logic [31:0] writeData3,
  output logic        cacheWrite,
  output logic [31:0] cacheWriteData0,
  output logic [31:0] cacheWriteData1,
  output logic [31:0] cacheWriteData2,
  output logic [31:0] cacheWriteData3,
  output logic        memRead,
  output logic [14:0] memAddr,
  input  logic        memReady,
  input  logic [31:0] memData
`ifdef CACHE_HIT_COUNTER_EN
  ,
  output logic [15:0] hitCount,
  output logic [15:0] missCount
`endif
);

  localparam int unsigned AddrW  = 15;
  localparam int unsigned DataW  = 32;
  localparam int unsigned CntW   = 2;
  localparam int unsigned NWords = 4;

  typedef enum logic [1:0] {IDLE, COMPARE, FETCH, FILL} stateType;

  stateType          state;
  logic [AddrW-1:0]  addrLatch;
  logic [CntW-1:0]   wordCnt;
  logic [CntW-1:0]   nextCnt;
  logic [DataW-1:0]  fillBuf [NWords];
  logic              hit;
  logic [DataW-1:0]  hitWord;

  assign indx    = addrLatch[11:2];
  assign TagIn   = addrLatch[14:12];
  assign hit     = valid && (TagOut == addrLatch[14:12]);
  assign nextCnt = wordCnt + CntW'(1);

  assign cacheWriteData0 = fillBuf[0];
  assign cacheWriteData1 = fillBuf[1];
  assign cacheWriteData2 = fillBuf[2];
  assign cacheWriteData3 = fillBuf[3];

  // Select the requested word out of the line read back from the cache
  always_comb begin
    hitWord = writeData0;
    case (addrLatch[1:0])
      2'd0:    hitWord = writeData0;
      2'd1:    hitWord = writeData1;
      2'd2:    hitWord = writeData2;
      default: hitWord = writeData3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addrLatch  <= '0;
      wordCnt    <= '0;
      cpuReady   <= 1'b0;
      cpuData    <= '0;
      cacheWrite <= 1'b0;
      memRead    <= 1'b0;
      memAddr    <= '0;
      for (int i = 0; i < int'(NWords); i++) fillBuf[i] <= '0;
    end else begin
      cpuReady   <= 1'b0;
      cacheWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (cpuRead) begin
            addrLatch <= cpuAddr;
            state     <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            cpuReady <= 1'b1;
            cpuData  <= hitWord;
            state    <= IDLE;
          end else begin
            wordCnt <= '0;
            memRead <= 1'b1;
            memAddr <= {addrLatch[14:2], 2'b00};
            state   <= FETCH;
          end
        end
        FETCH: begin
          if (memReady) begin
            fillBuf[wordCnt] <= memData;
            if (wordCnt == CntW'(3)) begin
              memRead    <= 1'b0;
              cacheWrite <= 1'b1;
              state      <= FILL;
            end else begin
              wordCnt <= nextCnt;
              memAddr <= {addrLatch[14:2], nextCnt};
            end
          end
        end
        FILL: begin
          // Line written this cycle; recheck so the read completes as an ordinary hit
          wordCnt <= '0;
          state   <= COMPARE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_HIT_COUNTER_EN
  logic filledThisReq;

  // Hits that needed a fill first are not counted as hits
  always_ff @(posedge clk) begin
    if (rst) begin
      filledThisReq <= 1'b0;
      hitCount      <= '0;
      missCount     <= '0;
    end else begin
      if (state == FILL) filledThisReq <= 1'b1;
      else if (state == IDLE) filledThisReq <= 1'b0;
      if (state == COMPARE && hit && !filledThisReq && hitCount != 16'hFFFF)
        hitCount <= hitCount + 16'd1;
      if (state == COMPARE && !hit && missCount != 16'hFFFF)
        missCount <= missCount + 16'd1;
    end
  end
`endif

endmodule
